// File: rtl/hdmi_pixel_if.sv
// Pixel-pipeline to HDMI-transmitter signal bundle for hdmi_pixel_port.
// The test_en input exists only when HDMI_TEST_PATTERN_EN is defined.
interface hdmi_pixel_if;
  // No valid/ready pair: display_enable qualifies each clk's pixel and the port never stalls.
  logic cga_mode, video, intensity, r, g, b;
  logic hsync, vsync, display_enable, switch2, switch3;
`ifdef HDMI_TEST_PATTERN_EN
  logic test_en;
`endif
  logic hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int;
  logic hdmi_hs, hdmi_vs, hdmi_de, hdmi_clk;

  modport master (
    output cga_mode, video, intensity, r, g, b,
    output hsync, vsync, display_enable, switch2, switch3,
    input  hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int,
    input  hdmi_hs, hdmi_vs, hdmi_de, hdmi_clk
`ifdef HDMI_TEST_PATTERN_EN
    , output test_en
`endif
  );

  modport slave (
    input  cga_mode, video, intensity, r, g, b,
    input  hsync, vsync, display_enable, switch2, switch3,
    output hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int,
    output hdmi_hs, hdmi_vs, hdmi_de, hdmi_clk
`ifdef HDMI_TEST_PATTERN_EN
    , input test_en
`endif
  );
endinterface

// File: rtl/hdmi_pixel_port.sv
// MDA/CGA pixel pipeline to HDMI transmitter: divided pixel clock, frame-locked palette,
// delay-aligned colour/sync/DE. Define HDMI_TEST_PATTERN_EN to add the 8-bar test pattern.
module hdmi_pixel_port #(
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1,
  parameter int DE_DELAY   = 1
) (
  input logic        clk,
  input logic        reset,
  hdmi_pixel_if.slave port
);
  localparam int CW       = $clog2(CLK_DIV);
  localparam int DE_DEPTH = PIPE_DELAY + DE_DELAY;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
`ifdef HDMI_TEST_PATTERN_EN
  localparam int CFG_W = 4;
`else
  localparam int CFG_W = 3;
`endif

  logic [CW-1:0]    cnt;
  logic             hdmi_clk_q;
  logic [CFG_W-1:0] cfg_in, cfg_s1, cfg_s2, cfg_c;
  logic             vsync_d;
  logic [1:0]       sel;
  logic             mode;
  logic             test_on;
  logic [2:0]       mda_rgb;
  logic [4:0]       colour;
  logic [6:0]       pipe_q [PIPE_DELAY];
  logic             de_q   [DE_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      hdmi_clk_q <= 1'b0;
    end else begin
      cnt        <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      hdmi_clk_q <= (cnt >= CNT_HALF);
    end
  end

  // Config bits: {[test_en,] cga_mode, switch2, switch3}
`ifdef HDMI_TEST_PATTERN_EN
  assign cfg_in  = {port.test_en, port.cga_mode, port.switch2, port.switch3};
  assign test_on = cfg_c[3];
`else
  assign cfg_in  = {port.cga_mode, port.switch2, port.switch3};
  assign test_on = 1'b0;
`endif
  assign sel  = cfg_c[1:0];
  assign mode = cfg_c[2];

  // Switches only take effect on a vsync rising edge so a frame is never painted in two palettes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_s1  <= '0;
      cfg_s2  <= '0;
      cfg_c   <= '0;
      vsync_d <= 1'b0;
    end else begin
      cfg_s1  <= cfg_in;
      cfg_s2  <= cfg_s1;
      vsync_d <= port.vsync;
      if (port.vsync && !vsync_d) cfg_c <= cfg_s2;
    end
  end

`ifdef HDMI_TEST_PATTERN_EN
  logic [9:0] px_cnt;
  always_ff @(posedge clk) begin
    if (reset || !port.display_enable) px_cnt <= '0;
    else if (cnt == CNT_MAX)           px_cnt <= px_cnt + 10'd1;
  end
`endif

  always_comb begin
    mda_rgb = 3'b010;
    case (sel)
      2'b01:   mda_rgb = 3'b110;
      2'b10:   mda_rgb = 3'b111;
      2'b11:   mda_rgb = 3'b100;
      default: mda_rgb = 3'b010;
    endcase
    if (mode) colour = {port.r, port.g, port.b, port.intensity, port.intensity};
    else      colour = {mda_rgb & {3{port.video}}, port.intensity, port.intensity};
    // CGA dark yellow is shown as brown: green drops to the low-intensity green LSB.
    if (mode && {port.r, port.g, port.b, port.intensity} == 4'b1100) colour = 5'b10001;
`ifdef HDMI_TEST_PATTERN_EN
    if (test_on) colour = {px_cnt[6:4], 2'b00};
`endif
    if (!test_on && 1'b0) colour = '0;
    if (!port.display_enable) colour = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= '0;
      for (int i = 0; i < DE_DEPTH; i++)   de_q[i]   <= 1'b0;
    end else begin
      pipe_q[0] <= {colour, port.hsync, port.vsync};
      for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      de_q[0] <= port.display_enable;
      for (int i = 1; i < DE_DEPTH; i++)   de_q[i]   <= de_q[i-1];
    end
  end

  assign port.hdmi_red     = pipe_q[PIPE_DELAY-1][6];
  assign port.hdmi_grn     = pipe_q[PIPE_DELAY-1][5];
  assign port.hdmi_blu     = pipe_q[PIPE_DELAY-1][4];
  assign port.hdmi_int     = pipe_q[PIPE_DELAY-1][3];
  assign port.hdmi_grn_int = pipe_q[PIPE_DELAY-1][2];
  assign port.hdmi_hs      = pipe_q[PIPE_DELAY-1][1];
  assign port.hdmi_vs      = pipe_q[PIPE_DELAY-1][0];
  assign port.hdmi_de      = de_q[DE_DEPTH-1];
  assign port.hdmi_clk     = hdmi_clk_q;
endmodule

// File: tb/tb_hdmi_pixel_port.sv
// Bench for hdmi_pixel_port: two instances (different divide/delay settings) checked every
// cycle against a frame-level model, plus directed literal checks.
module tb_hdmi_pixel_port;
  localparam int DIV_A = 2, PIPE_A = 2, DE_A = 1;
  localparam int DIV_B = 4, PIPE_B = 1, DE_B = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic cga_mode, video, intensity, r, g, b, hsync, vsync, de, sw2, sw3, test_en;
  int   checks = 0;
  int   failures = 0;

  hdmi_pixel_if if_a();
  hdmi_pixel_if if_b();
  assign if_a.cga_mode = cga_mode;  assign if_b.cga_mode = cga_mode;
  assign if_a.video = video;        assign if_b.video = video;
  assign if_a.intensity = intensity; assign if_b.intensity = intensity;
  assign if_a.r = r; assign if_a.g = g; assign if_a.b = b;
  assign if_b.r = r; assign if_b.g = g; assign if_b.b = b;
  assign if_a.hsync = hsync;        assign if_b.hsync = hsync;
  assign if_a.vsync = vsync;        assign if_b.vsync = vsync;
  assign if_a.display_enable = de;  assign if_b.display_enable = de;
  assign if_a.switch2 = sw2;        assign if_b.switch2 = sw2;
  assign if_a.switch3 = sw3;        assign if_b.switch3 = sw3;
`ifdef HDMI_TEST_PATTERN_EN
  assign if_a.test_en = test_en;    assign if_b.test_en = test_en;
`endif

  hdmi_pixel_port #(.CLK_DIV(DIV_A), .PIPE_DELAY(PIPE_A), .DE_DELAY(DE_A))
    dut_a (.clk(clk), .reset(rst), .port(if_a.slave));
  hdmi_pixel_port #(.CLK_DIV(DIV_B), .PIPE_DELAY(PIPE_B), .DE_DELAY(DE_B))
    dut_b (.clk(clk), .reset(rst), .port(if_b.slave));

  // {de, red, grn, blu, int, grn_int, hs, vs, clk}
  wire [8:0] out_a = {if_a.hdmi_de, if_a.hdmi_red, if_a.hdmi_grn, if_a.hdmi_blu, if_a.hdmi_int,
                      if_a.hdmi_grn_int, if_a.hdmi_hs, if_a.hdmi_vs, if_a.hdmi_clk};
  wire [8:0] out_b = {if_b.hdmi_de, if_b.hdmi_red, if_b.hdmi_grn, if_b.hdmi_blu, if_b.hdmi_int,
                      if_b.hdmi_grn_int, if_b.hdmi_hs, if_b.hdmi_vs, if_b.hdmi_clk};

  // ---------------- model ----------------
  logic [2:0] h1, h2;         // {switch2, switch3, cga_mode} seen one and two clks ago
  logic       t1, t2;
  logic       vs_prev;
  logic [1:0] m_sel;
  logic       m_mode, m_test;
  int         k_a, k_b, ph;   // clk edges since reset release
  logic [9:0] px_a, px_b;
  logic [7:0] exp_q_a[$], exp_q_b[$];  // per-edge {de, colour, hs, vs}, newest first
  logic       hclk_a, hclk_b;
  logic [8:0] exp_a, exp_b;
  bit         started = 1'b0;

  function automatic logic [4:0] exp_colour(input logic [1:0] sel, input logic mode, tst,
                                            input logic [9:0] px, input logic dv, vid, inten,
                                            rr, gg, bb);
    logic [2:0] mda_tab [4];
    mda_tab = '{3'b010, 3'b110, 3'b111, 3'b100};
    if (!dv) return 5'b0;
    if (tst) return {px[6:4], 2'b00};
    if (!mode) return {(vid ? mda_tab[sel] : 3'b000), inten, inten};
    if ({rr, gg, bb, inten} == 4'b1100) return 5'b10001;
    return {rr, gg, bb, inten, inten};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      h1 = '0; h2 = '0; t1 = 1'b0; t2 = 1'b0; vs_prev = 1'b0;
      m_sel = '0; m_mode = 1'b0; m_test = 1'b0;
      k_a = 0; k_b = 0; px_a = '0; px_b = '0; hclk_a = 1'b0; hclk_b = 1'b0;
      exp_q_a = {}; exp_q_b = {};
      for (int i = 0; i < 8; i++) begin
        exp_q_a.push_front(8'h00);
        exp_q_b.push_front(8'h00);
      end
    end else begin
      exp_q_a.push_front({de, exp_colour(m_sel, m_mode, m_test, px_a, de, video, intensity, r, g, b),
                          hsync, vsync});
      exp_q_b.push_front({de, exp_colour(m_sel, m_mode, m_test, px_b, de, video, intensity, r, g, b),
                          hsync, vsync});
      void'(exp_q_a.pop_back());
      void'(exp_q_b.pop_back());
      ph = k_a % DIV_A;
      hclk_a = (ph >= DIV_A / 2);
      if (!de) px_a = '0; else if (ph == DIV_A - 1) px_a = px_a + 10'd1;
      k_a++;
      ph = k_b % DIV_B;
      hclk_b = (ph >= DIV_B / 2);
      if (!de) px_b = '0; else if (ph == DIV_B - 1) px_b = px_b + 10'd1;
      k_b++;
      if (vsync && !vs_prev) begin
        m_sel  = h2[2:1];
        m_mode = h2[0];
        m_test = t2;
      end
      h2 = h1; h1 = {sw2, sw3, cga_mode};
      t2 = t1;
`ifdef HDMI_TEST_PATTERN_EN
      t1 = test_en;
`else
      t1 = 1'b0;
`endif
      vs_prev = vsync;
    end
    exp_a = {exp_q_a[PIPE_A+DE_A-1][7], exp_q_a[PIPE_A-1][6:0], hclk_a};
    exp_b = {exp_q_b[PIPE_B+DE_B-1][7], exp_q_b[PIPE_B-1][6:0], hclk_b};
    started = 1'b1;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (out_a !== exp_a) begin
        failures++;
        $display("FAIL model_a t=%0t got=%b exp=%b", $time, out_a, exp_a);
      end
      checks++;
      if (out_b !== exp_b) begin
        failures++;
        $display("FAIL model_b t=%0t got=%b exp=%b", $time, out_b, exp_b);
      end
    end
  end

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_all(input logic v);
    cga_mode = v; video = v; intensity = v; r = v; g = v; b = v;
    hsync = v; vsync = v; de = v; sw2 = v; sw3 = v; test_en = v;
  endtask

  task automatic set_rgbi(input logic [3:0] v);
    {r, g, b, intensity} = v;
  endtask

  // ---------------- directed stimulus ----------------
  logic [3:0] want_clk_a, want_clk_b;
  int         hi_cnt, edges;
  logic       prev_clk;

  initial begin
    want_clk_a = 4'b1010;   // hdmi_clk after release edges 4..1, CLK_DIV=2
    want_clk_b = 4'b1100;   // same for CLK_DIV=4
    set_all(1'b1);
    rst = 1'b1;
    tick(3);
    check("reset_a", out_a, 9'h000);
    check("reset_b", out_b, 9'h000);

    set_all(1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("hclk_a", {8'h00, out_a[0]}, {8'h00, want_clk_a[e-1]});
      check("hclk_b", {8'h00, out_b[0]}, {8'h00, want_clk_b[e-1]});
    end

    // one-clk MDA green pixel
    de = 1'b1; video = 1'b1;
    tick();
    de = 1'b0; video = 1'b0;
    check("lat_b_grn_de", {7'h0, out_b[8], out_b[6]}, 9'h003);
    check("lat_a_early", {7'h0, out_a[8], out_a[6]}, 9'h000);
    tick();
    check("lat_a_grn", {7'h0, out_a[8], out_a[6]}, 9'h001);
    tick();
    check("lat_a_de", {7'h0, out_a[8], out_a[6]}, 9'h002);

    // palette change mid-frame waits for vsync
    sw2 = 1'b1; sw3 = 1'b0; de = 1'b1; video = 1'b1; hsync = 1'b1;
    tick(5);
    check("frame_hold", {6'h0, out_a[7:5]}, 9'b010);
    vsync = 1'b1;
    tick();
    vsync = 1'b0; hsync = 1'b0;
    tick();
    check("frame_old", {6'h0, out_a[7:5]}, 9'b010);
    tick();
    check("frame_white", {6'h0, out_a[7:5]}, 9'b111);

    // vsync held high: exactly one commit
    vsync = 1'b1;
    tick();
    sw3 = 1'b1;
    tick(6);
    check("vs_held", {6'h0, out_a[7:5]}, 9'b111);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick(2);
    check("frame_red", {6'h0, out_a[7:5]}, 9'b100);

    // CGA mapping
    cga_mode = 1'b1;
    tick(3);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    set_rgbi(4'b1100);
    tick(2);
    check("cga_brown", {4'h0, out_a[7:3]}, 9'b10001);
    set_rgbi(4'b1111);
    tick(2);
    check("cga_white", {4'h0, out_a[7:3]}, 9'b11111);
    set_rgbi(4'b0101);
    tick(2);
    check("cga_grn_i", {4'h0, out_a[7:3]}, 9'b01011);

    // blanking
    de = 1'b0; video = 1'b1; set_rgbi(4'b1111);
    tick(2);
    check("blank_a", {4'h0, out_a[7:3]}, 9'h000);
    check("blank_b", {4'h0, out_b[7:3]}, 9'h000);

    // CLK_DIV=4 divider: 4 high of 8, 4 transitions
    hi_cnt = 0; edges = 0; prev_clk = out_b[0];
    for (int i = 0; i < 8; i++) begin
      tick();
      hi_cnt += int'(out_b[0]);
      if (out_b[0] != prev_clk) edges++;
      prev_clk = out_b[0];
    end
    check("div_b_high", 9'(hi_cnt), 9'd4);
    check("div_b_edges", 9'(edges), 9'd4);

    // reset in the middle of active video
    de = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_mid_a", out_a, 9'h000);
    check("rst_mid_b", out_b, 9'h000);
    rst = 1'b0;
    tick();
    check("rst_rel_a", {out_a[8:1], 1'b0}, 9'h000);

`ifdef HDMI_TEST_PATTERN_EN
    de = 1'b0; test_en = 1'b1;
    tick(3);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    if (k_a % DIV_A != 0) tick();
    de = 1'b1; video = 1'b0;
    for (int j = 0; j < 230; j++) begin
      tick();
      if (j == 1)   check("tp_px0",   {4'h0, out_a[7:3]}, 9'b00000);
      if (j == 31)  check("tp_px15",  {4'h0, out_a[7:3]}, 9'b00000);
      if (j == 33)  check("tp_px16",  {4'h0, out_a[7:3]}, 9'b00100);
      if (j == 225) check("tp_px112", {4'h0, out_a[7:3]}, 9'b11100);
    end
    de = 1'b0;
    tick(2);
    check("tp_blank", {4'h0, out_a[7:3]}, 9'h000);
`endif

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
